// File: rtl/psram_bist.sv
`default_nettype none
// ============================================================================
// Module      : psram_bist
// Description : Built-in self-test engine for the PSRAM controller path.
//               Writes a data pattern over an address range, reads it back,
//               compares each word, and classifies each operation's latency
//               as 1x or 2x. Supports an optional inverted second pass,
//               stop-on-error, error capture, per-operation timeouts and abort.
// Revision    : 1.0 - initial release
// ============================================================================
module psram_bist #(
  parameter int ADDR_W  = 22,
  parameter int DATA_W  = 16,
  parameter int LATENCY = 4,
  parameter int CNT_W   = 24,
  parameter int WR_TO   = 8 + 2 * LATENCY,
  parameter int RD_TO   = 13 + 2 * LATENCY
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        pattern,
  input  logic              two_pass,
  input  logic              stop_on_err,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic              mem_busy,
  output logic [2:0]        state,
  output logic              done,
  output logic              pass,
  output logic              phase,
  output logic [1:0]        fail_code,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_act,
  output logic [CNT_W-1:0]  wr_1x,
  output logic [CNT_W-1:0]  wr_2x,
  output logic [CNT_W-1:0]  rd_1x,
  output logic [CNT_W-1:0]  rd_2x
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_ISSUE = 3'd1,
    S_WR_WAIT  = 3'd2,
    S_RD_ISSUE = 3'd3,
    S_RD_WAIT  = 3'd4,
    S_DRAIN    = 3'd5,
    S_DONE     = 3'd6,
    S_FAIL     = 3'd7
  } state_t;

  // Wait-cycle counter only needs to reach the larger of the two timeouts.
  localparam int c_to_max = (WR_TO > RD_TO) ? WR_TO : RD_TO;
  localparam int c_cyc_w  = $clog2(c_to_max + 1);

  localparam logic [c_cyc_w-1:0] c_cyc_one = c_cyc_w'(1);
  localparam logic [c_cyc_w-1:0] c_cyc_min = c_cyc_w'(2);
  localparam logic [c_cyc_w-1:0] c_wr_to   = c_cyc_w'(WR_TO);
  localparam logic [c_cyc_w-1:0] c_rd_to   = c_cyc_w'(RD_TO);
  localparam logic [c_cyc_w-1:0] c_wr_2x   = c_cyc_w'(5 + LATENCY);
  localparam logic [c_cyc_w-1:0] c_rd_2x   = c_cyc_w'(10 + LATENCY);
  localparam logic [ADDR_W-1:0]  c_addr_one = ADDR_W'(1);

  // Expected data for word address a in the given pattern and pass.
  function automatic logic [DATA_W-1:0] exp_data(
    input logic [ADDR_W-1:0] a,
    input logic [1:0]        pat,
    input logic              ph
  );
    logic [7:0]        h;
    logic [DATA_W-1:0] d;
    h = 8'hC3;
    // Fold the low, middle and upper address bytes; upper field is zero-extended.
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 8; k++) begin
        if (b * 8 + k < ADDR_W) h[k] = h[k] ^ a[b * 8 + k];
      end
    end
    d = '0;
    case (pat)
      2'd0: begin
        for (int b = 0; b < DATA_W / 8; b++) d[b * 8 +: 8] = h;
      end
      2'd1: begin
        for (int i = 0; i < DATA_W; i++) begin
          if (i < ADDR_W) d[i] = a[i];
        end
      end
      2'd2: begin
        for (int i = 0; i < DATA_W; i++) d[i] = ((a % ADDR_W'(DATA_W)) == ADDR_W'(i));
      end
      default: begin
        for (int b = 0; b < DATA_W / 8; b++) d[b * 8 +: 8] = a[0] ? 8'hAA : 8'h55;
      end
    endcase
    if (ph) d = ~d;
    return d;
  endfunction

  // Saturating counter increment.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   start_addr_q, start_addr_d;
  logic [ADDR_W-1:0]   last_addr_q, last_addr_d;
  logic [1:0]          pattern_q, pattern_d;
  logic                two_pass_q, two_pass_d;
  logic                stop_q, stop_d;
  logic                phase_q, phase_d;
  logic [c_cyc_w-1:0]  cyc_q, cyc_d;
  logic [1:0]          fail_code_q, fail_code_d;
  logic [CNT_W-1:0]    err_count_q, err_count_d;
  logic [ADDR_W-1:0]   fe_addr_q, fe_addr_d;
  logic [DATA_W-1:0]   fe_exp_q, fe_exp_d;
  logic [DATA_W-1:0]   fe_act_q, fe_act_d;
  logic [CNT_W-1:0]    wr_1x_q, wr_1x_d;
  logic [CNT_W-1:0]    wr_2x_q, wr_2x_d;
  logic [CNT_W-1:0]    rd_1x_q, rd_1x_d;
  logic [CNT_W-1:0]    rd_2x_q, rd_2x_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_din_q, mem_din_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;

  logic [DATA_W-1:0]   w_exp_cur;
  logic                w_complete;
  logic                w_last;
  logic                w_launch;
  logic                w_miss;

  // Next-state, datapath and request generation.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    start_addr_d = start_addr_q;
    last_addr_d  = last_addr_q;
    pattern_d    = pattern_q;
    two_pass_d   = two_pass_q;
    stop_d       = stop_q;
    phase_d      = phase_q;
    cyc_d        = cyc_q;
    fail_code_d  = fail_code_q;
    err_count_d  = err_count_q;
    fe_addr_d    = fe_addr_q;
    fe_exp_d     = fe_exp_q;
    fe_act_d     = fe_act_q;
    wr_1x_d      = wr_1x_q;
    wr_2x_d      = wr_2x_q;
    rd_1x_d      = rd_1x_q;
    rd_2x_d      = rd_2x_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;

    w_exp_cur  = exp_data(addr_q, pattern_q, phase_q);
    w_complete = !mem_busy && (cyc_q >= c_cyc_min);
    w_last     = (addr_q == last_addr_q);
    w_miss     = (mem_dout != w_exp_cur);
    w_launch   = start && !abort && (start_addr <= last_addr) &&
                 ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_FAIL));

    case (state_q)
      S_WR_ISSUE, S_RD_ISSUE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          state_d = (state_q == S_WR_ISSUE) ? S_WR_WAIT : S_RD_WAIT;
          cyc_d   = c_cyc_one;
        end
      end
      S_WR_WAIT: begin
        // Timeout outranks abort; abort outranks completion.
        if (!w_complete && (cyc_q == c_wr_to)) begin
          state_d     = S_FAIL;
          fail_code_d = 2'd2;
        end else if (abort) begin
          state_d = S_DRAIN;
        end else if (w_complete) begin
          if (cyc_q > c_wr_2x) wr_2x_d = sat_inc(wr_2x_q);
          else                 wr_1x_d = sat_inc(wr_1x_q);
          if (w_last) begin
            addr_d  = start_addr_q;
            state_d = S_RD_ISSUE;
          end else begin
            addr_d  = addr_q + c_addr_one;
            state_d = S_WR_ISSUE;
          end
        end else begin
          cyc_d = cyc_q + c_cyc_one;
        end
      end
      S_RD_WAIT: begin
        if (!w_complete && (cyc_q == c_rd_to)) begin
          state_d     = S_FAIL;
          fail_code_d = 2'd3;
        end else if (abort) begin
          state_d = S_DRAIN;
        end else if (w_complete) begin
          if (cyc_q > c_rd_2x) rd_2x_d = sat_inc(rd_2x_q);
          else                 rd_1x_d = sat_inc(rd_1x_q);
          if (w_miss) begin
            err_count_d = sat_inc(err_count_q);
            if (err_count_q == '0) begin
              fe_addr_d = addr_q;
              fe_exp_d  = w_exp_cur;
              fe_act_d  = mem_dout;
            end
          end
          if (w_miss && stop_q) begin
            state_d     = S_FAIL;
            fail_code_d = 2'd1;
          end else if (w_last) begin
            if (!phase_q && two_pass_q) begin
              phase_d = 1'b1;
              addr_d  = start_addr_q;
              state_d = S_WR_ISSUE;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            addr_d  = addr_q + c_addr_one;
            state_d = S_RD_ISSUE;
          end
        end else begin
          cyc_d = cyc_q + c_cyc_one;
        end
      end
      S_DRAIN: begin
        // Let the outstanding controller operation finish before idling.
        if (!mem_busy) state_d = S_IDLE;
      end
      S_DONE, S_FAIL: begin
        if (abort) state_d = S_IDLE;
      end
      default: begin
      end
    endcase

    if (w_launch) begin
      state_d      = S_WR_ISSUE;
      start_addr_d = start_addr;
      last_addr_d  = last_addr;
      pattern_d    = pattern;
      two_pass_d   = two_pass;
      stop_d       = stop_on_err;
      phase_d      = 1'b0;
      addr_d       = start_addr;
      fail_code_d  = 2'd0;
      err_count_d  = '0;
      fe_addr_d    = '0;
      fe_exp_d     = '0;
      fe_act_d     = '0;
      wr_1x_d      = '0;
      wr_2x_d      = '0;
      rd_1x_d      = '0;
      rd_2x_d      = '0;
    end

    if (state_d == S_IDLE) fail_code_d = 2'd0;

    // Request pulse is registered so it coincides with the ISSUE state.
    if ((state_d == S_WR_ISSUE) || (state_d == S_RD_ISSUE)) begin
      mem_addr_d = addr_d;
      if (state_d == S_WR_ISSUE) begin
        mem_write_d = 1'b1;
        mem_din_d   = exp_data(addr_d, pattern_d, phase_d);
      end else begin
        mem_read_d  = 1'b1;
      end
    end

    done_d = (state_d == S_DONE);
    pass_d = (state_d == S_DONE) && (err_count_d == '0);
  end

  // State and datapath registers; reset clears every output immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      start_addr_q <= '0;
      last_addr_q  <= '0;
      pattern_q    <= '0;
      two_pass_q   <= 1'b0;
      stop_q       <= 1'b0;
      phase_q      <= 1'b0;
      cyc_q        <= '0;
      fail_code_q  <= '0;
      err_count_q  <= '0;
      fe_addr_q    <= '0;
      fe_exp_q     <= '0;
      fe_act_q     <= '0;
      wr_1x_q      <= '0;
      wr_2x_q      <= '0;
      rd_1x_q      <= '0;
      rd_2x_q      <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      start_addr_q <= start_addr_d;
      last_addr_q  <= last_addr_d;
      pattern_q    <= pattern_d;
      two_pass_q   <= two_pass_d;
      stop_q       <= stop_d;
      phase_q      <= phase_d;
      cyc_q        <= cyc_d;
      fail_code_q  <= fail_code_d;
      err_count_q  <= err_count_d;
      fe_addr_q    <= fe_addr_d;
      fe_exp_q     <= fe_exp_d;
      fe_act_q     <= fe_act_d;
      wr_1x_q      <= wr_1x_d;
      wr_2x_q      <= wr_2x_d;
      rd_1x_q      <= rd_1x_d;
      rd_2x_q      <= rd_2x_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  assign state          = state_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_addr       = mem_addr_q;
  assign mem_din        = mem_din_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign phase          = phase_q;
  assign fail_code      = fail_code_q;
  assign err_count      = err_count_q;
  assign first_err_addr = fe_addr_q;
  assign first_err_exp  = fe_exp_q;
  assign first_err_act  = fe_act_q;
  assign wr_1x          = wr_1x_q;
  assign wr_2x          = wr_2x_q;
  assign rd_1x          = rd_1x_q;
  assign rd_2x          = rd_2x_q;

endmodule
`default_nettype wire

// File: doc/psram_bist.md
# psram_bist

Parametrised built-in self-test engine for the PSRAM controller path. It writes a configurable data pattern over a word-address range, reads the range back, compares every word and keeps 1x/2x latency counters. It supports four patterns, an optional inverted second pass, continue-on-error with error capture, per-operation timeouts and abort. It sits between the board top (buttons, LEDs, UART print) and `PsramController`, on the controller clock.

## Interface
- `ADDR_W`, 22: word address width.
- `DATA_W`, 16: data width; must be a multiple of 8.
- `LATENCY`, 4: controller latency setting; used for 1x/2x classification.
- `CNT_W`, 24: width of error and latency counters; all saturate.
- `WR_TO`, 8+2*LATENCY: write timeout, in cycles after issue.
- `RD_TO`, 13+2*LATENCY: read timeout, in cycles after issue.

- `clk`  in  1  controller clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  pulse; accepted only in IDLE, DONE or FAIL.
- `abort`  in  1  pulse; terminates the run.
- `pattern`  in  2  0 = hash, 1 = address, 2 = walking-one, 3 = checkerboard.
- `two_pass`  in  1  adds a second write/read pass with inverted data.
- `stop_on_err`  in  1  go to FAIL on the first mismatch.
- `start_addr`, `last_addr`  in  ADDR_W  inclusive range.
- `mem_read`, `mem_write`  out  1  one-cycle request pulses to the controller.
- `mem_addr`  out  ADDR_W  request address.
- `mem_din`  out  DATA_W  write data.
- `mem_dout`  in  DATA_W  read data from the controller.
- `mem_busy`  in  1  controller busy.
- `state`  out  3  0 IDLE, 1 WR_ISSUE, 2 WR_WAIT, 3 RD_ISSUE, 4 RD_WAIT, 5 DRAIN, 6 DONE, 7 FAIL.
- `done`  out  1  high in DONE.
- `pass`  out  1  high in DONE when `err_count` is 0.
- `phase`  out  1  current pass (0 or 1).
- `fail_code`  out  2  0 none, 1 mismatch stop, 2 write timeout, 3 read timeout.
- `err_count`  out  CNT_W  number of mismatched words.
- `first_err_addr`  out  ADDR_W  address of the first mismatch.
- `first_err_exp`, `first_err_act`  out  DATA_W  expected and actual data at the first mismatch.
- `wr_1x`, `wr_2x`, `rd_1x`, `rd_2x`  out  CNT_W  latency counters.

## Operation
- **Reset:** every output is 0 and `state` is IDLE.
- **Start:**
  - Accepted only when `start_addr <= last_addr`; otherwise it is ignored and the block stays in its current state.
  - On acceptance the block latches `pattern`, `two_pass`, `stop_on_err` and the range, clears all counters, captures and `fail_code`, sets `phase`=0 and `addr`=`start_addr`, and enters WR_ISSUE.
- **Expected data exp(a)**, XORed with all-ones when `phase`=1:
  - hash: byte h = a[7:0]^a[15:8]^a[ADDR_W-1:16]^8'hC3 (zero-extended), replicated across DATA_W.
  - address: a zero-extended or truncated to DATA_W.
  - walking-one: 1 << (a mod DATA_W).
  - checkerboard: a[0] ? 0xAA.. : 0x55..
- **WR_ISSUE:** pulses `mem_write` with `mem_addr`=addr and `mem_din`=exp(addr), then enters WR_WAIT.
- **WR_WAIT:**
  - Completion is the first cycle with `mem_busy`=0 and cycle count c>=2, where c=1 is the cycle after issue.
  - Latency counter: `wr_2x`++ if c>5+LATENCY, else `wr_1x`++.
  - If addr==`last_addr`: addr<=`start_addr` and go to RD_ISSUE. Otherwise addr++ and go to WR_ISSUE.
  - Reaching c==WR_TO without completion goes to FAIL with `fail_code`=2.
- **RD_ISSUE / RD_WAIT:** same structure, using `mem_read`, the 10+LATENCY threshold and RD_TO (`fail_code`=3). On completion `mem_dout` is compared with exp(addr).
  - On mismatch: `err_count`++. If it was 0, capture addr, exp and `mem_dout`. Then, if `stop_on_err`, go to FAIL with `fail_code`=1.
  - After the read of `last_addr`: if `phase`=0 and `two_pass`, set `phase`<=1, addr<=`start_addr` and go to WR_ISSUE. Otherwise go to DONE.
- **Timeouts** go to FAIL regardless of `stop_on_err`.
- **Abort:**
  - From ISSUE, DONE or FAIL: go to IDLE next cycle.
  - From WR_WAIT or RD_WAIT: go to DRAIN, which holds until `mem_busy`=0 and then goes to IDLE.
  - No request pulses are issued after abort.
  - Counters are held; `done`, `pass` and `fail_code` are cleared in IDLE.
- **Simultaneous events:** `abort` beats `start`; a timeout beats `abort` in the same cycle.
- **Range end:** termination is by address equality, so `last_addr` = all-ones causes no wrap.

## Timing
- Request pulses are registered and last exactly one cycle, with `mem_addr` and `mem_din` valid in the same cycle.
- At most one request is outstanding at any time.
- Minimum cost per word is 3 cycles (issue plus c>=2).
- Compare, capture and counter updates are registered on the completion edge and visible the next cycle.
- `state`, `done` and `pass` are registered.
- The address increment may be pipelined but must not add per-word cycles.
- Asynchronous reset mid-operation drops all request pulses immediately.

## Test plan
- **Clean run:** hash, range 0..15, model with 3-cycle busy → DONE, `pass`=1, `wr_1x`=`rd_1x`=16, `err_count`=0.
- **Continue on error:** model flips bit 0 at address 5, `stop_on_err`=0 → DONE, `pass`=0, `err_count`=1, `first_err_addr`=5, exp=0xC6C6, act=0xC6C7; reads continue through address 15.
- **Stop on error:** same corruption with `stop_on_err`=1 → FAIL, `fail_code`=1, no `mem_read` issued for address 6.
- **Timeouts and 2x latency:**
  - `mem_busy` held high on the write to address 2 → FAIL, `fail_code`=2, exactly WR_TO cycles after issue.
  - 12-cycle busy → `wr_2x` increments.
- **Two-pass walking-one:** range 0..17 → 72 requests; the phase-1 read of address 17 expects 0xFFFD; `pass`=1.
- **Abort and reset:**
  - `abort` in RD_WAIT with busy high → DRAIN until busy falls, then IDLE with no further pulses.
  - `start` with `start_addr`>`last_addr` is ignored.
  - Reset mid-write → all outputs 0.
